// File: rtl/rv32_pipeline_pkg.sv
// Purpose: shared RV32 pipeline types and constants (NOP encoding, fetch-queue entry, mcause codes).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pipeline_pkg;

    localparam int RV32_XLEN = 32;

    // addi x0, x0, 0 -- substituted for the encoding of faulting fetches.
    localparam logic [31:0] RV32_NOP = 32'h0000_0013;

    // Synchronous exception causes that fetch can raise (mcause, interrupt bit clear).
    localparam logic [3:0] MCAUSE_NONE                = 4'd0;
    localparam logic [3:0] MCAUSE_INSTR_ADDR_MISALIGN = 4'd0;
    localparam logic [3:0] MCAUSE_INSTR_ACCESS_FAULT  = 4'd1;
    localparam logic [3:0] MCAUSE_ILLEGAL_INSTR       = 4'd2;
    localparam logic [3:0] MCAUSE_BREAKPOINT          = 4'd3;
    localparam logic [3:0] MCAUSE_INSTR_PAGE_FAULT    = 4'd12;

    typedef struct packed {
        logic [RV32_XLEN-1:0] pc;
        logic [31:0]          instr;
        logic                 exception;
        logic [3:0]           exception_cause;
        logic                 branch_predicted_taken;
    } rv32_fq_entry_t;

endpackage

// File: rtl/rv32_fq_storage.sv
// Purpose: DEPTH-entry register array for the fetch queue; one write port, one async read port, no reset.
// Latency: write visible on rd_data the cycle after wr_en; read is combinational.
// Backpressure: none; the caller only asserts wr_en on an accepted push.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port.
module rv32_fq_storage
    import rv32_pipeline_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  rv32_fq_entry_t           wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output rv32_fq_entry_t           rd_data
);

    rv32_fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rv32_decode_queue.sv
// Purpose: DEPTH-entry fetch->decode instruction queue with flush, clock enable and occupancy reporting.
// Latency: one cycle from accepted push to head visibility (first-word fall-through from storage).
// Backpressure: in_ready = !full only; a full queue refuses a push even when decode pops that cycle.
// Ports: clk/reset (sync, active-high); ce_i gates all state; flush_in empties the queue;
//        in_* = fetch-side entry + valid/ready; out_* = head entry + valid/ready;
//        count_out/empty_out/full_out = occupancy.
module rv32_decode_queue
    import rv32_pipeline_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ce_i,
    input  logic                     flush_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_exception,
    input  logic [3:0]               in_exception_cause,
    input  logic                     in_branch_predicted_taken,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_exception,
    output logic [3:0]               out_exception_cause,
    output logic                     out_branch_predicted_taken,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     empty_out,
    output logic                     full_out
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           empty;
    logic           full;
    logic           push;
    logic           pop;
    rv32_fq_entry_t wr_entry;
    rv32_fq_entry_t rd_entry;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign push = ce_i && in_valid && !full && !flush_in;
    assign pop  = ce_i && !empty && out_ready && !flush_in;

    // A faulting fetch carries no usable encoding, so decode sees a NOP; a clean
    // fetch has no cause, so the field is cleared rather than passed through.
    always_comb begin
        wr_entry                        = '0;
        wr_entry.pc                     = RV32_XLEN'(in_pc);
        wr_entry.instr                  = in_exception ? RV32_NOP : in_instr;
        wr_entry.exception              = in_exception;
        wr_entry.exception_cause        = in_exception ? in_exception_cause : MCAUSE_NONE;
        wr_entry.branch_predicted_taken = in_branch_predicted_taken;
    end

    rv32_fq_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_entry)
    );

    // Flush only resets pointers; stale storage is masked by the empty check below.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (ce_i) begin
            if (flush_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count_out = wr_ptr - rd_ptr;
    assign empty_out = empty;
    assign full_out  = full;

    assign out_pc                     = empty ? '0 : rd_entry.pc[PC_WIDTH-1:0];
    assign out_instr                  = empty ? '0 : rd_entry.instr;
    assign out_exception              = empty ? 1'b0 : rd_entry.exception;
    assign out_exception_cause        = empty ? 4'd0 : rd_entry.exception_cause;
    assign out_branch_predicted_taken = empty ? 1'b0 : rd_entry.branch_predicted_taken;

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Purpose: self-checking bench for rv32_decode_queue against a queue-based reference model.
// Latency: model updates on each rising edge; outputs are compared on the following falling edge.
// Backpressure: stimulus drives out_ready/ce_i/flush_in/reset both directed and at random.
module tb_rv32_decode_queue;

    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce_i;
    logic          flush_in;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pc;
    logic [31:0]   in_instr;
    logic          in_exception;
    logic [3:0]    in_exception_cause;
    logic          in_branch_predicted_taken;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pc;
    logic [31:0]   out_instr;
    logic          out_exception;
    logic [3:0]    out_exception_cause;
    logic          out_branch_predicted_taken;
    logic [CW-1:0] count_out;
    logic          empty_out;
    logic          full_out;

    always #5 clk = ~clk;

    rv32_decode_queue #(
        .DEPTH    (DEPTH),
        .PC_WIDTH (PW)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .ce_i                       (ce_i),
        .flush_in                   (flush_in),
        .in_valid                   (in_valid),
        .in_ready                   (in_ready),
        .in_pc                      (in_pc),
        .in_instr                   (in_instr),
        .in_exception               (in_exception),
        .in_exception_cause         (in_exception_cause),
        .in_branch_predicted_taken  (in_branch_predicted_taken),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_pc                     (out_pc),
        .out_instr                  (out_instr),
        .out_exception              (out_exception),
        .out_exception_cause        (out_exception_cause),
        .out_branch_predicted_taken (out_branch_predicted_taken),
        .count_out                  (count_out),
        .empty_out                  (empty_out),
        .full_out                   (full_out)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  cause;
        logic        tag;
    } ent_t;

    ent_t model[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        ent_t h;
        int   n;
        h = '{pc: 32'd0, instr: 32'd0, exc: 1'b0, cause: 4'd0, tag: 1'b0};
        n = model.size();
        if (n > 0) h = model[0];
        chk({tag, " out_valid"}, 64'(out_valid), 64'(n != 0));
        chk({tag, " count"},     64'(count_out), 64'(n));
        chk({tag, " empty"},     64'(empty_out), 64'(n == 0));
        chk({tag, " full"},      64'(full_out),  64'(n == DEPTH));
        chk({tag, " in_ready"},  64'(in_ready),  64'(n != DEPTH));
        chk({tag, " out_pc"},    64'(out_pc),    64'(h.pc));
        chk({tag, " out_instr"}, 64'(out_instr), 64'(h.instr));
        chk({tag, " out_exc"},   64'(out_exception), 64'(h.exc));
        chk({tag, " out_cause"}, 64'(out_exception_cause), 64'(h.cause));
        chk({tag, " out_tag"},   64'(out_branch_predicted_taken), 64'(h.tag));
    endtask

    // Advance one clock: predict from the current inputs, then compare after the edge.
    task automatic cycle(input string tag);
        bit   push;
        bit   pop;
        ent_t e;
        push = !reset && ce_i && !flush_in && in_valid && (model.size() < DEPTH);
        pop  = !reset && ce_i && !flush_in && out_ready && (model.size() > 0);
        e.pc    = in_pc;
        e.exc   = in_exception;
        e.instr = in_exception ? 32'h0000_0013 : in_instr;
        e.cause = in_exception ? in_exception_cause : 4'd0;
        e.tag   = in_branch_predicted_taken;
        @(posedge clk);
        if (reset || (ce_i && flush_in)) begin
            model.delete();
        end else begin
            if (pop) void'(model.pop_front());
            if (push) model.push_back(e);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic exc, input logic [3:0] cause, input logic tag);
        in_valid                  = v;
        in_pc                     = pc;
        in_instr                  = instr;
        in_exception              = exc;
        in_exception_cause        = cause;
        in_branch_predicted_taken = tag;
    endtask

    initial begin
        reset     = 1'b1;
        ce_i      = 1'b1;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        cycle("reset");
        cycle("reset");
        chk("reset count", 64'(count_out), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset empty", 64'(empty_out), 64'd1);
        reset = 1'b0;

        // Two pushes with decode stalled; head visible one cycle after the first push.
        set_in(1'b1, 32'h100, 32'h0000_0093, 1'b0, 4'd7, 1'b1);
        cycle("push1");
        chk("first head pc", 64'(out_pc), 64'h100);
        set_in(1'b1, 32'h104, 32'h0010_0113, 1'b0, 4'd0, 1'b0);
        cycle("push2");
        chk("two count", 64'(count_out), 64'd2);
        chk("two in_ready", 64'(in_ready), 64'd1);

        // Fill to DEPTH; the fifth offer must be refused.
        set_in(1'b1, 32'h108, 32'h0020_0193, 1'b0, 4'd0, 1'b1);
        cycle("push3");
        set_in(1'b1, 32'h10C, 32'h0030_0213, 1'b0, 4'd0, 1'b0);
        cycle("push4");
        chk("full flag", 64'(full_out), 64'd1);
        chk("full in_ready", 64'(in_ready), 64'd0);
        set_in(1'b1, 32'h110, 32'h0040_0293, 1'b0, 4'd0, 1'b0);
        cycle("push5 refused");
        chk("refused count", 64'(count_out), 64'd4);

        // Drain in order.
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain order", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
            cycle("drain");
        end
        chk("drained empty", 64'(empty_out), 64'd1);

        // Streaming at occupancy 1; pointers have wrapped so indices restart at 0.
        out_ready = 1'b0;
        set_in(1'b1, 32'h200, 32'h1111_1113, 1'b0, 4'd0, 1'b0);
        cycle("stream prime");
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'h204 + 32'(4 * i), 32'h2000_0013 + 32'(i), 1'b0, 4'd0, 1'(i));
            cycle("stream");
            chk("stream count", 64'(count_out), 64'd1);
            chk("stream pc", 64'(out_pc), 64'(32'h204 + 32'(4 * i)));
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        cycle("stream drain");

        // Faulting fetch becomes a NOP with its cause preserved.
        out_ready = 1'b0;
        set_in(1'b1, 32'h300, 32'hFFFF_FFFF, 1'b1, 4'd1, 1'b1);
        cycle("exc push");
        chk("exc flag", 64'(out_exception), 64'd1);
        chk("exc cause", 64'(out_exception_cause), 64'd1);
        chk("exc instr nop", 64'(out_instr), 64'h13);
        set_in(1'b1, 32'h304, 32'h0050_0313, 1'b0, 4'd5, 1'b0);
        cycle("clean push");
        set_in(1'b1, 32'h308, 32'h0060_0393, 1'b0, 4'd0, 1'b1);
        cycle("third push");

        // Flush with a concurrent push: everything, including the push, is discarded.
        flush_in = 1'b1;
        set_in(1'b1, 32'h30C, 32'h0070_0413, 1'b0, 4'd0, 1'b1);
        cycle("flush");
        chk("flush count", 64'(count_out), 64'd0);
        chk("flush valid", 64'(out_valid), 64'd0);
        chk("flush pc", 64'(out_pc), 64'd0);
        flush_in = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        cycle("post flush");

        // Clock-enable low freezes everything despite active handshakes.
        set_in(1'b1, 32'h400, 32'h0080_0493, 1'b0, 4'd0, 1'b0);
        cycle("ce fill1");
        set_in(1'b1, 32'h404, 32'h0090_0513, 1'b0, 4'd0, 1'b0);
        cycle("ce fill2");
        ce_i      = 1'b0;
        out_ready = 1'b1;
        set_in(1'b1, 32'h408, 32'h00A0_0593, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("ce hold");
            chk("ce hold count", 64'(count_out), 64'd2);
            chk("ce hold pc", 64'(out_pc), 64'h400);
        end
        ce_i = 1'b1;

        // Reset mid-operation behaves like a flush.
        out_ready = 1'b0;
        reset     = 1'b1;
        cycle("mid reset");
        chk("mid reset count", 64'(count_out), 64'd0);
        chk("mid reset in_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0);
        cycle("post reset");

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                   1'($urandom_range(0, 5) == 0), 4'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            ce_i      = 1'($urandom_range(0, 7) != 0);
            flush_in  = 1'($urandom_range(0, 40) == 0);
            reset     = 1'($urandom_range(0, 100) == 0);
            cycle("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32_decode_queue.md
# rv32_decode_queue

Parametrised instruction queue between the fetch and decode stages of the RV32 pipeline, replacing the single-entry fetch→decode register with a DEPTH-entry FIFO. It decouples fetch from decode stalls and carries each instruction's PC, encoding, fetch exception and branch-prediction tag. It supports pipeline flush, clock-enable gating and occupancy reporting. Decode consumes the head entry through a valid/ready handshake.

## Interface

- DEPTH, 4, number of entries; power of two, ≥2.
- PC_WIDTH, 32, width of stored PC.

- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ce_i  in  1  clock enable; when low, all state holds.
- flush_in  in  1  discard all entries (from hazard unit).
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue accepts an entry this cycle.
- in_pc  in  PC_WIDTH  fetched PC.
- in_instr  in  32  fetched instruction.
- in_exception  in  1  fetch fault on this entry.
- in_exception_cause  in  4  mcause code of the fault.
- in_branch_predicted_taken  in  1  predictor tag.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode consumes head (decode drives !stall).
- out_pc  out  PC_WIDTH  head PC.
- out_instr  out  32  head instruction.
- out_exception  out  1  head fault flag.
- out_exception_cause  out  4  head fault cause.
- out_branch_predicted_taken  out  1  head predictor tag.
- count_out  out  $clog2(DEPTH)+1  occupancy.
- empty_out  out  1  count_out == 0.
- full_out  out  1  count_out == DEPTH.

## Operation

- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. Index uses the low bits. Full when the index bits are equal and the MSBs differ; empty when the pointers are equal.
- in_ready = !full_out. It is not combinationally dependent on out_ready; a full queue refuses a push even if a pop happens in the same cycle.
- Push = ce_i && in_valid && in_ready && !flush_in. Pop = ce_i && out_valid && out_ready && !flush_in.
- Push and pop in the same cycle: both pointers advance and count is unchanged. This is legal at any non-full occupancy ≥1.
- Entries with in_exception=1 store instr = RV32_NOP (32'h00000013). pc, cause and tag are stored as presented.
- Entries with in_exception=0 store cause = 0.
- Flush: both pointers go to 0 and any concurrent push is discarded. Flush takes priority over push and pop.
- ce_i=0: pointers and storage hold. Handshake outputs still reflect the current state.
- Output is first-word fall-through from storage at rd_ptr. All out_* data fields are forced to 0 when empty, so they never expose stale data.
- Reset: pointers 0. Reset value of every output: out_valid 0, all out_* data 0, count_out 0, empty_out 1, full_out 0, in_ready 1. Storage contents are not reset.
- Reset mid-operation: all entries are lost, identical to a flush. Reset dominates ce_i.

## Timing

- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1.
- Throughput: one push and one pop per cycle.
- Outputs are registered-state only: no combinational path from any in_* port or out_ready to any output.
- A flush asserted in cycle N gives out_valid=0 and count_out=0 in cycle N+1.
- out_* fields hold steady while out_valid=1 and out_ready=0.

## Structure

- The shared package rv32_pipeline_pkg holds:
  - RV32_NOP.
  - The entry struct rv32_fq_entry_t: pc, instr, exception, exception_cause, branch_predicted_taken.
  - The mcause constant definitions used by the queue.
- One sub-module, rv32_fq_storage: DEPTH×entry register array with one write port and one asynchronous read port, no reset. The pointer, count and flag logic lives in the top module.

## Test plan

- Reset, then push pc 0x100 and 0x104 with out_ready=0 -> count_out=2; out_pc=0x100 from the cycle after the first push; in_ready=1.
- DEPTH=4: push 4 entries with out_ready=0 -> full_out=1 and in_ready=0. A 5th in_valid is ignored; after draining, 4 entries come out in order with wrap-around to index 0 verified.
- Continuous push and pop at occupancy 1 for 10 cycles -> count_out stays 1; the PC sequence appears in order with one-cycle latency.
- Push an entry with in_exception=1, cause 4'd1, instr 0xFFFFFFFF -> out_exception=1, out_exception_cause=1, out_instr=0x00000013.
- With 3 entries queued, assert flush_in together with in_valid=1 -> the next cycle shows count_out=0, out_valid=0 and all out_* fields 0; the concurrent push is dropped.
- Hold ce_i=0 for 3 cycles with in_valid=1 and out_ready=1 -> count_out and out_pc are unchanged. Assert reset during a partially full queue -> all outputs take their reset values the next cycle.
